stage4_mem: RTL and testbench

- Memory stage of the 8-bit pipeline, directly downstream of the execute stage.
- Holds the EX/MEM pipeline register and an internal data memory, and drives the MEM/WB pipeline register.
- Loads and stores take MEM_LATENCY cycles; while an access is incomplete, the block raises `stall` to freeze upstream stages.
- Exports Ex_Mem_aluResult and Mem_Wb_aluResult, which the execute stage's forwarding muxes consume.

---
 rtl/stage4_mem.sv | 173 +++++++++++++++++
 tb/tb_stage4_mem.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stage4_mem.sv
// Memory stage: EX/MEM pipeline register, data memory with a multi-cycle
// access counter, and the MEM/WB pipeline register. Loads and stores hold
// the stage for MEM_LATENCY cycles and stall upstream while incomplete.
module stage4_mem #(
    parameter int WORD_LENGTH    = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int MEM_LATENCY    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WORD_LENGTH-1:0]    aluResultIn,
    input  logic [WORD_LENGTH-1:0]    storeDataIn,
    input  logic [REG_ADDR_WIDTH-1:0] destRegIn,
    input  logic                      regWriteIn,
    input  logic                      memReadIn,
    input  logic                      memWriteIn,
    input  logic                      memToRegIn,
    output logic                      stall,
    output logic [WORD_LENGTH-1:0]    Ex_Mem_aluResult,
    output logic [REG_ADDR_WIDTH-1:0] Ex_Mem_destReg,
    output logic                      Ex_Mem_regWrite,
    output logic [WORD_LENGTH-1:0]    Mem_Wb_aluResult,
    output logic [REG_ADDR_WIDTH-1:0] Mem_Wb_destReg,
    output logic                      Mem_Wb_regWrite
);

    // Counter value on the final (completing) cycle of a memory access.
    localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

    // EX/MEM pipeline register fields
    logic [WORD_LENGTH-1:0]    ex_alu_q,      ex_alu_d;
    logic [WORD_LENGTH-1:0]    ex_store_q,    ex_store_d;
    logic [REG_ADDR_WIDTH-1:0] ex_dest_q,     ex_dest_d;
    logic                      ex_regwr_q,    ex_regwr_d;
    logic                      ex_memrd_q,    ex_memrd_d;
    logic                      ex_memwr_q,    ex_memwr_d;
    logic                      ex_memtoreg_q, ex_memtoreg_d;

    // Access counter: 0 is IDLE, any non-zero value is WAIT.
    logic [3:0] cnt_q, cnt_d;

    // MEM/WB pipeline register fields
    logic [WORD_LENGTH-1:0]    wb_data_q,  wb_data_d;
    logic [REG_ADDR_WIDTH-1:0] wb_dest_q,  wb_dest_d;
    logic                      wb_regwr_q, wb_regwr_d;

    // Data memory; contents survive reset.
    logic [WORD_LENGTH-1:0] mem [2**ADDR_WIDTH];

    logic                   mem_op;
    logic                   last_cycle;
    logic                   stall_int;
    logic                   store_commit;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [WORD_LENGTH-1:0] rd_data;

    // Decode of the registered instruction; read+write together acts as a load.
    always_comb begin
        mem_op     = ex_memrd_q | ex_memwr_q;
        last_cycle = (cnt_q == LAST_CNT);
        addr       = ex_alu_q[ADDR_WIDTH-1:0];
        rd_data    = mem[addr];
    end

    // Access FSM output logic: depends only on registered state.
    always_comb begin
        stall_int    = mem_op & ~last_cycle;
        store_commit = mem_op & last_cycle & ex_memwr_q & ~ex_memrd_q;
    end

    // Access FSM next-state: count stalled cycles, clear on completion.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_int) begin
            cnt_d = cnt_q + 4'd1;
        end else if (mem_op) begin
            cnt_d = 4'd0;
        end
    end

    // Access FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // EX/MEM next values: capture new instruction unless the stage is busy.
    always_comb begin
        ex_alu_d      = ex_alu_q;
        ex_store_d    = ex_store_q;
        ex_dest_d     = ex_dest_q;
        ex_regwr_d    = ex_regwr_q;
        ex_memrd_d    = ex_memrd_q;
        ex_memwr_d    = ex_memwr_q;
        ex_memtoreg_d = ex_memtoreg_q;
        if (!stall_int) begin
            ex_alu_d      = aluResultIn;
            ex_store_d    = storeDataIn;
            ex_dest_d     = destRegIn;
            ex_regwr_d    = regWriteIn;
            ex_memrd_d    = memReadIn;
            ex_memwr_d    = memWriteIn;
            ex_memtoreg_d = memToRegIn;
        end
    end

    // EX/MEM register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_alu_q      <= '0;
            ex_store_q    <= '0;
            ex_dest_q     <= '0;
            ex_regwr_q    <= 1'b0;
            ex_memrd_q    <= 1'b0;
            ex_memwr_q    <= 1'b0;
            ex_memtoreg_q <= 1'b0;
        end else begin
            ex_alu_q      <= ex_alu_d;
            ex_store_q    <= ex_store_d;
            ex_dest_q     <= ex_dest_d;
            ex_regwr_q    <= ex_regwr_d;
            ex_memrd_q    <= ex_memrd_d;
            ex_memwr_q    <= ex_memwr_d;
            ex_memtoreg_q <= ex_memtoreg_d;
        end
    end

    // MEM/WB next values: retire the instruction, or issue a bubble while stalled.
    always_comb begin
        wb_data_d  = wb_data_q;
        wb_dest_d  = wb_dest_q;
        wb_regwr_d = 1'b0;
        if (!stall_int) begin
            wb_data_d  = ex_memtoreg_q ? rd_data : ex_alu_q;
            wb_dest_d  = ex_dest_q;
            wb_regwr_d = ex_regwr_q;
        end
    end

    // MEM/WB register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_data_q  <= '0;
            wb_dest_q  <= '0;
            wb_regwr_q <= 1'b0;
        end else begin
            wb_data_q  <= wb_data_d;
            wb_dest_q  <= wb_dest_d;
            wb_regwr_q <= wb_regwr_d;
        end
    end

    // Store commits only on the completing edge; reset clears mem_op so an
    // interrupted store never reaches the array.
    always_ff @(posedge clk) begin
        if (store_commit) begin
            mem[addr] <= ex_store_q;
        end
    end

    assign stall            = stall_int;
    assign Ex_Mem_aluResult = ex_alu_q;
    assign Ex_Mem_destReg   = ex_dest_q;
    assign Ex_Mem_regWrite  = ex_regwr_q;
    assign Mem_Wb_aluResult = wb_data_q;
    assign Mem_Wb_destReg   = wb_dest_q;
    assign Mem_Wb_regWrite  = wb_regwr_q;

endmodule

// File: tb/tb_stage4_mem.sv
// Bench for stage4_mem: four instances with MEM_LATENCY 1..4 (index i has
// latency i+1), driven one instruction at a time as a frozen upstream would,
// and compared against an instruction-level model of memory and writeback.
module tb_stage4_mem;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] alu_in  [4];
    logic [7:0] st_in   [4];
    logic [2:0] dest_in [4];
    logic       rw_in   [4];
    logic       mr_in   [4];
    logic       mw_in   [4];
    logic       mtr_in  [4];

    wire        stall_o  [4];
    wire  [7:0] exm_alu  [4];
    wire  [2:0] exm_dest [4];
    wire        exm_rw   [4];
    wire  [7:0] mwb_data [4];
    wire  [2:0] mwb_dest [4];
    wire        mwb_rw   [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            stage4_mem #(
                .WORD_LENGTH(8), .ADDR_WIDTH(8), .REG_ADDR_WIDTH(3), .MEM_LATENCY(gi + 1)
            ) u_dut (
                .clk(clk), .rst(rst),
                .aluResultIn(alu_in[gi]), .storeDataIn(st_in[gi]), .destRegIn(dest_in[gi]),
                .regWriteIn(rw_in[gi]), .memReadIn(mr_in[gi]), .memWriteIn(mw_in[gi]),
                .memToRegIn(mtr_in[gi]), .stall(stall_o[gi]),
                .Ex_Mem_aluResult(exm_alu[gi]), .Ex_Mem_destReg(exm_dest[gi]),
                .Ex_Mem_regWrite(exm_rw[gi]), .Mem_Wb_aluResult(mwb_data[gi]),
                .Mem_Wb_destReg(mwb_dest[gi]), .Mem_Wb_regWrite(mwb_rw[gi])
            );
        end
    endgenerate

    int checks = 0;
    int errors = 0;

    // Model: memory contents, which addresses are known, and the writeback
    // each instance owes for the instruction currently in its EX/MEM.
    logic [7:0] mem_m   [4][256];
    bit         known   [4][256];
    logic [7:0] exp_data [4];
    logic [2:0] exp_dest [4];
    logic       exp_rw   [4];

    task automatic drive_nop(input int i);
        alu_in[i] = 8'h00; st_in[i] = 8'h00; dest_in[i] = 3'd0;
        rw_in[i] = 1'b0; mr_in[i] = 1'b0; mw_in[i] = 1'b0; mtr_in[i] = 1'b0;
    endtask

    task automatic clear_expect();
        for (int i = 0; i < 4; i++) begin
            exp_data[i] = 8'h00; exp_dest[i] = 3'd0; exp_rw[i] = 1'b0;
        end
    endtask

    // Present one instruction, hold it through the stall, check EX/MEM,
    // the retiring writeback, bubbles and stall length, then update the model.
    task automatic step_instr(input int i, input logic [7:0] alu, input logic [7:0] st,
                              input logic [2:0] dest, input logic rw, input logic mr,
                              input logic mw, input logic mtr);
        int n;
        int want;
        logic [7:0] wb;
        alu_in[i] = alu; st_in[i] = st; dest_in[i] = dest;
        rw_in[i] = rw; mr_in[i] = mr; mw_in[i] = mw; mtr_in[i] = mtr;
        @(posedge clk); #1;
        checks++;
        if (exm_alu[i] !== alu || exm_dest[i] !== dest || exm_rw[i] !== rw) begin
            errors++;
            $display("FAIL exmem lat%0d got %h/%0d/%b want %h/%0d/%b", i + 1,
                     exm_alu[i], exm_dest[i], exm_rw[i], alu, dest, rw);
        end
        checks++;
        if (mwb_data[i] !== exp_data[i] || mwb_dest[i] !== exp_dest[i] || mwb_rw[i] !== exp_rw[i]) begin
            errors++;
            $display("FAIL memwb lat%0d got %h/%0d/%b want %h/%0d/%b", i + 1,
                     mwb_data[i], mwb_dest[i], mwb_rw[i], exp_data[i], exp_dest[i], exp_rw[i]);
        end
        want = (mr || mw) ? i : 0;
        n = 0;
        while (stall_o[i] === 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
            checks++;
            if (mwb_rw[i] !== 1'b0 || mwb_data[i] !== exp_data[i] || mwb_dest[i] !== exp_dest[i] ||
                exm_alu[i] !== alu || exm_dest[i] !== dest || exm_rw[i] !== rw) begin
                errors++;
                $display("FAIL bubble lat%0d cyc%0d got wb %h/%0d/%b ex %h/%0d/%b want wb %h/%0d/0 ex %h/%0d/%b",
                         i + 1, n, mwb_data[i], mwb_dest[i], mwb_rw[i], exm_alu[i], exm_dest[i],
                         exm_rw[i], exp_data[i], exp_dest[i], alu, dest, rw);
            end
        end
        checks++;
        if (n != want) begin
            errors++;
            $display("FAIL stall_cycles lat%0d got %0d want %0d", i + 1, n, want);
        end
        wb = mtr ? mem_m[i][alu] : alu;
        if (mw && !mr) begin
            mem_m[i][alu] = st;
            known[i][alu] = 1'b1;
        end
        exp_data[i] = wb; exp_dest[i] = dest; exp_rw[i] = rw;
    endtask

    task automatic check_wb(input int i, input logic [7:0] d, input logic [2:0] r, input string name);
        checks++;
        if (mwb_data[i] !== d || mwb_dest[i] !== r || mwb_rw[i] !== 1'b1) begin
            errors++;
            $display("FAIL %s got %h/%0d/%b want %h/%0d/1", name, mwb_data[i], mwb_dest[i], mwb_rw[i], d, r);
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (stall_o[i] !== 1'b0 || exm_alu[i] !== 8'h00 || exm_dest[i] !== 3'd0 ||
                exm_rw[i] !== 1'b0 || mwb_data[i] !== 8'h00 || mwb_dest[i] !== 3'd0 || mwb_rw[i] !== 1'b0) begin
                errors++;
                $display("FAIL %s lat%0d got stall %b ex %h/%0d/%b wb %h/%0d/%b want all 0", name, i + 1,
                         stall_o[i], exm_alu[i], exm_dest[i], exm_rw[i], mwb_data[i], mwb_dest[i], mwb_rw[i]);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            alu_in[i] = 8'($urandom); st_in[i] = 8'($urandom); dest_in[i] = 3'($urandom);
            rw_in[i] = 1'($urandom); mr_in[i] = 1'($urandom); mw_in[i] = 1'b0;
            mtr_in[i] = 1'($urandom);
        end
        repeat (5) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check_all_zero("reset_async");
        @(posedge clk); #1;
        check_all_zero("reset_held");
        @(negedge clk);
        for (int i = 0; i < 4; i++) drive_nop(i);
        rst = 1'b0;
        clear_expect();
    endtask

    task automatic test_alu_pass();
        step_instr(1, 8'h3C, 8'h00, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step_instr(1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_wb(1, 8'h3C, 3'd5, "alu_pass");
    endtask

    task automatic test_store_load();
        step_instr(1, 8'h10, 8'hA5, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step_instr(1, 8'h10, 8'h00, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        step_instr(1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_wb(1, 8'hA5, 3'd2, "store_load");
    endtask

    task automatic test_latency_sweep();
        step_instr(0, 8'h30, 8'h77, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step_instr(0, 8'h30, 8'h00, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        step_instr(0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_wb(0, 8'h77, 3'd1, "lat1_load");
        step_instr(3, 8'h31, 8'h99, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step_instr(3, 8'h31, 8'h00, 3'd6, 1'b1, 1'b1, 1'b0, 1'b1);
        step_instr(3, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_wb(3, 8'h99, 3'd6, "lat4_load");
    endtask

    task automatic test_reset_mid_store();
        step_instr(2, 8'h20, 8'h5A, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step_instr(2, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        alu_in[2] = 8'h20; st_in[2] = 8'hFF; mw_in[2] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (stall_o[2] !== 1'b1) begin
            errors++;
            $display("FAIL mid_store_stall got %b want 1", stall_o[2]);
        end
        rst = 1'b1;
        #1;
        check_all_zero("mid_store_reset");
        @(posedge clk); #1;
        @(negedge clk);
        drive_nop(2);
        rst = 1'b0;
        clear_expect();
        step_instr(2, 8'h20, 8'h00, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        step_instr(2, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_wb(2, 8'h5A, 3'd3, "mid_store_old_data");
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 30; k++) begin
                logic [7:0] a;
                logic mr, mw, mtr;
                int kind;
                kind = int'($urandom_range(0, 3));
                a = 8'h40 + 8'($urandom_range(0, 7));
                mr = (kind == 2) || (kind == 3);
                mw = (kind == 1) || (kind == 3);
                mtr = (kind == 2 || kind == 3 || ($urandom_range(0, 3) == 0)) && known[i][a] && !(kind == 1);
                step_instr(i, (kind == 0 && !mtr) ? 8'($urandom) : a, 8'($urandom), 3'($urandom),
                           1'($urandom), mr, mw, mtr);
            end
            step_instr(i, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            drive_nop(i);
            for (int a = 0; a < 256; a++) begin
                known[i][a] = 1'b0;
                mem_m[i][a] = 8'h00;
            end
        end
        clear_expect();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_alu_pass();
        test_store_load();
        test_latency_sweep();
        test_reset_mid_store();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
